// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the multi-port register file.
// FSM state encoding lives here so the top and any tooling agree on it.
package regfile_pkg;

  typedef enum logic {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_e;

  localparam int RF_DATA_W = 16;
  localparam int RF_NREGS  = 8;

endpackage

// File: rtl/regfile_mp_if.sv
// Write/read/clear bus of the register file; master drives requests, slave returns read data.
// Read results are combinational on the slave side; there is no backpressure, writes during a clear sweep are dropped.
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = $clog2(RF_NREGS)
);

  logic [DATA_W-1:0] data_in;
  logic [ADDR_W-1:0] writenum;
  logic              write;
  logic [ADDR_W-1:0] readnum_a;
  logic [ADDR_W-1:0] readnum_b;
  logic [DATA_W-1:0] data_out_a;
  logic [DATA_W-1:0] data_out_b;
  logic              valid_a;
  logic              valid_b;
  logic              clear;
  logic              busy;

  modport master (
    output data_in, writenum, write, readnum_a, readnum_b, clear,
    input  data_out_a, data_out_b, valid_a, valid_b, busy
  );

  modport slave (
    input  data_in, writenum, write, readnum_a, readnum_b, clear,
    output data_out_a, data_out_b, valid_a, valid_b, busy
  );

endinterface

// File: rtl/regfile_rdport.sv
// One combinational read port: index mux over the flop array with optional write forwarding.
// Zero latency; an unwritten register reads as 0 with valid low.
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int NREGS  = RF_NREGS,
  parameter int ADDR_W = $clog2(NREGS),
  parameter int BYPASS = 1
) (
  input  logic [NREGS-1:0][DATA_W-1:0] regs_i,
  input  logic [NREGS-1:0]             valid_i,
  input  logic [ADDR_W-1:0]            raddr_i,
  input  logic                         wr_en_i,
  input  logic [ADDR_W-1:0]            waddr_i,
  input  logic [DATA_W-1:0]            wdata_i,
  output logic [DATA_W-1:0]            data_o,
  output logic                         valid_o
);

  logic fwd_hit;

  // wr_en_i already excludes writes that arrive during a clear sweep
  assign fwd_hit = (BYPASS != 0) && wr_en_i && (waddr_i == raddr_i);

  always_comb begin
    data_o  = '0;
    valid_o = 1'b0;
    if (fwd_hit) begin
      data_o  = wdata_i;
      valid_o = 1'b1;
    end else if (valid_i[raddr_i]) begin
      data_o  = regs_i[raddr_i];
      valid_o = 1'b1;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Two-read/one-write register file with per-entry valid bits and a sequential clear sweep.
// Reads are combinational; writes commit on the rising edge and are dropped while busy (NREGS-cycle sweep).
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int NREGS  = RF_NREGS,
  parameter int ADDR_W = $clog2(NREGS),
  parameter int BYPASS = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  regfile_mp_if.slave bus
);

  rf_state_e                    state_q, state_d;
  logic [ADDR_W-1:0]            idx_q, idx_d;
  logic [NREGS-1:0][DATA_W-1:0] regs_q, regs_d;
  logic [NREGS-1:0]             valid_q, valid_d;
  logic                         busy;
  logic                         wr_en;
  logic                         last_idx;

  assign wr_en    = bus.write && !busy;
  assign last_idx = (idx_q == ADDR_W'(NREGS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RF_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // A clear that arrives mid-sweep is not looked at, so the sweep never restarts.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      RF_IDLE: begin
        if (bus.clear) begin
          state_d = RF_CLEAR;
          idx_d   = '0;
        end
      end
      RF_CLEAR: begin
        idx_d = idx_q + ADDR_W'(1);
        if (last_idx) begin
          state_d = RF_IDLE;
        end
      end
      default: begin
        state_d = RF_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_comb begin
    busy = (state_q == RF_CLEAR);
  end

  assign bus.busy = busy;

  // Writes and the sweep are mutually exclusive; a write in the clear-request cycle lands first.
  always_comb begin
    regs_d  = regs_q;
    valid_d = valid_q;
    if (wr_en) begin
      regs_d[bus.writenum]  = bus.data_in;
      valid_d[bus.writenum] = 1'b1;
    end
    if (busy) begin
      regs_d[idx_q]  = '0;
      valid_d[idx_q] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q  <= '0;
      valid_q <= '0;
    end else begin
      regs_q  <= regs_d;
      valid_q <= valid_d;
    end
  end

  regfile_rdport #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS),
    .ADDR_W (ADDR_W),
    .BYPASS (BYPASS)
  ) u_rd_a (
    .regs_i  (regs_q),
    .valid_i (valid_q),
    .raddr_i (bus.readnum_a),
    .wr_en_i (wr_en),
    .waddr_i (bus.writenum),
    .wdata_i (bus.data_in),
    .data_o  (bus.data_out_a),
    .valid_o (bus.valid_a)
  );

  regfile_rdport #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS),
    .ADDR_W (ADDR_W),
    .BYPASS (BYPASS)
  ) u_rd_b (
    .regs_i  (regs_q),
    .valid_i (valid_q),
    .raddr_i (bus.readnum_b),
    .wr_en_i (wr_en),
    .waddr_i (bus.writenum),
    .wdata_i (bus.data_in),
    .data_o  (bus.data_out_b),
    .valid_o (bus.valid_b)
  );

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter DATA_W, default 16, register width in bits.
REQ-002 Parameter NREGS, default 8, number of registers; SHALL be a power of two, 2..64.
REQ-003 Parameter ADDR_W, default $clog2(NREGS), register index width.
REQ-004 Parameter BYPASS, default 1, 1 enables write-to-read forwarding, 0 disables it.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 data_in  input  DATA_W  write data.
REQ-008 writenum  input  ADDR_W  write index.
REQ-009 write  input  1  write enable, sampled on rising clk.
REQ-010 readnum_a / readnum_b  input  ADDR_W each  read indices, ports A and B.
REQ-011 data_out_a / data_out_b  output  DATA_W each  read data, ports A and B.
REQ-012 valid_a / valid_b  output  1 each  read register has been written since last reset or clear.
REQ-013 clear  input  1  single-cycle request to start a clear sweep.
REQ-014 busy  output  1  clear sweep in progress.

Function
REQ-015 Writes SHALL be synchronous: on rising clk with write=1 and busy=0, register[writenum] <= data_in and valid[writenum] <= 1.
REQ-016 A write while busy=1 SHALL be dropped, with no change to any register or valid bit.
REQ-017 Reads SHALL be combinational and need no clock edge: data_out_x = register[readnum_x] and valid_x = valid[readnum_x].
REQ-018 A register with valid=0 SHALL read as data 0 with valid_x=0, never X.
REQ-019 With BYPASS=1, write=1, busy=0 and readnum_x==writenum, port x SHALL forward data_in with valid_x=1 in the same cycle.
REQ-020 With BYPASS=0, reads in the write cycle SHALL return the pre-edge contents.
REQ-021 Both ports SHALL operate independently and SHALL be able to read the same index simultaneously.
REQ-022 The FSM SHALL have two states, IDLE and CLEAR; busy=1 exactly while in CLEAR.
REQ-023 IDLE->CLEAR on rising clk with clear=1; the sweep index idx loads 0.
REQ-024 In CLEAR, each cycle SHALL zero register[idx], set valid[idx]=0, and increment idx.
REQ-025 CLEAR->IDLE after idx=NREGS-1 is cleared; busy SHALL be high for exactly NREGS cycles.
REQ-026 clear asserted while busy=1 SHALL be ignored; the sweep does not restart.
REQ-027 During CLEAR, reads SHALL return current contents; a cleared index reads 0 with valid 0, an uncleared index keeps its old value.
REQ-028 If clear=1 and write=1 in the same IDLE cycle, the write SHALL commit first, and that register is then cleared by the sweep.

Reset
REQ-029 While rst_n=0 (asynchronous): all registers 0, all valid bits 0, state IDLE, idx 0, busy 0.
REQ-030 Reset asserted mid-sweep SHALL abort the sweep immediately; after release the block is in IDLE with everything cleared.
REQ-031 The first write SHALL be accepted on the first rising clk after rst_n deasserts.

Structure
REQ-032 Package regfile_pkg SHALL hold the FSM state enum (RF_IDLE, RF_CLEAR) and default DATA_W/NREGS constants.
REQ-033 Read-mux-plus-bypass logic SHALL be one sub-module, regfile_rdport, instantiated twice.
REQ-034 Storage SHALL be a flop array of NREGS x DATA_W plus an NREGS-bit valid vector; no RAM macro.

Verification
REQ-035 Reset, then read every index on both ports -> data 0, valid 0, no X.
REQ-036 Write 42 to R3; set readnum_a=3, readnum_b=1 between edges -> A=42/valid 1, B=0/valid 0; the value is unchanged until the rising edge.
REQ-037 BYPASS=1: write=1, writenum=2, data_in=420, readnum_a=2, pre-edge -> data_out_a=420, valid_a=1. Repeat with BYPASS=0 -> old value.
REQ-038 Fill R0..R7 with 1..8, pulse clear -> busy high for 8 cycles; a write of 69 to R1 mid-sweep is dropped; after the sweep all registers read 0/valid 0.
REQ-039 Pulse clear, assert rst_n=0 at sweep cycle 3 -> busy=0 immediately and all registers 0; a write after release succeeds.
REQ-040 NREGS=32, DATA_W=32: write 0xDEADBEEF to R31 -> both ports read it at index 31; index 0 reads 0.
